parking_fee_calc: RTL and testbench
===================================

PARKING_FEE_CALC -- requirements
Module: parking_fee_calc

Interface
REQ-001 Parameter N_SLOTS, default 4, SHALL set the number of parking slots tracked.
REQ-002 Parameter RATE, default 5, SHALL set the fee units charged per started hour.
REQ-003 Parameter GRACE_MIN, default 15, SHALL set the stay length in minutes below which the fee is zero.
REQ-004 Parameter FEE_CAP, default 50, SHALL set the maximum fee per stay when capping is compiled in.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be synchronous, active-high.
REQ-007 hour  input  6  SHALL carry the time-of-day hour, 0..23, from the upstream timer.
REQ-008 minute  input  6  SHALL carry the time-of-day minute, 0..59, from the upstream timer.
REQ-009 car_in  input  1  SHALL be a one-cycle request to register an arrival at slot.
REQ-010 car_out  input  1  SHALL be a one-cycle request to register a departure from slot.
REQ-011 slot  input  2  SHALL carry the slot index for car_in/car_out.
REQ-012 busy  output  1  SHALL be high while a departure calculation is in progress.
REQ-013 done  output  1  SHALL pulse high for one cycle when fee and elapsed are valid.
REQ-014 fee  output  8  SHALL carry the fee of the last completed departure.
REQ-015 elapsed  output  11  SHALL carry the stay length in minutes of the last completed departure.
REQ-016 occupied  output  N_SLOTS  SHALL show one bit per slot, high while a car is parked.
REQ-017 err  output  1  SHALL pulse high for one cycle when a request is rejected.

Function
REQ-018 Timestamps SHALL be hour*60+minute (11 bits, 0..1439), sampled at the edge that accepts a request.
REQ-019 Requests SHALL be accepted only while busy=0; requests while busy=1 SHALL be ignored without err.
REQ-020 Accepted car_in on a free slot SHALL store the timestamp and set occupied[slot] at that edge; no busy, no done.
REQ-021 car_in on an occupied slot, car_out on a free slot, or car_in and car_out both high SHALL assert err next cycle and change no state.
REQ-022 Accepted car_out SHALL move the FSM IDLE->CALC, with busy high from the next cycle.
REQ-023 CALC SHALL compute elapsed = (exit - entry) mod 1440, so a midnight crossing wraps; equal stamps give 0; stays of 24 h or longer are not distinguishable.
REQ-024 DIV SHALL iteratively subtract min(remaining,60) per cycle, counting H = ceil(elapsed/60), range 0..24.
REQ-025 When remaining reaches 0, the FSM SHALL return to IDLE, pulse done, update fee and elapsed, clear occupied[slot], and drop busy in the same cycle.
REQ-026 done SHALL assert exactly H+2 cycles after the accepting cycle.
REQ-027 fee SHALL be 0 when elapsed < GRACE_MIN, otherwise H*RATE, saturated at 255.
REQ-028 fee and elapsed SHALL hold their values until the next done.
REQ-029 hour and minute SHALL be within range from upstream; out-of-range values are not checked and give undefined results.

Reset
REQ-030 reset SHALL force the FSM to IDLE and set busy=0, done=0, err=0, fee=0, elapsed=0, and occupied=0.
REQ-031 reset during CALC/DIV SHALL abort the calculation with no done pulse and free all slots.
REQ-032 reset SHALL take priority over simultaneous car_in/car_out.

Configuration
REQ-033 With FEE_CAP_EN defined, fee SHALL be min(H*RATE, FEE_CAP) after the grace rule.
REQ-034 Without FEE_CAP_EN, no cap SHALL apply beyond 8-bit saturation, and FEE_CAP is unused.

Verification
REQ-035 Arrival at slot 1 at 10:05 and departure at 12:06 -> elapsed=121, H=3, fee=15, done 5 cycles after acceptance, occupied[1] cleared.
REQ-036 Arrival at slot 0 at 23:50 and departure at 00:20 -> elapsed=30, fee=5.
REQ-037 Departure 10 minutes after arrival -> elapsed=10, fee=0, done 3 cycles after acceptance.
REQ-038 car_in on an occupied slot, car_out on a free slot, and both requests in one cycle -> err pulses each time, occupied unchanged, no done.
REQ-039 Arrival at 08:00 and departure at 07:59 -> elapsed=1439, H=24, fee=50 with FEE_CAP_EN and 120 without.
REQ-040 reset asserted during DIV -> no done, busy=0, occupied=0; a following car_in is accepted normally.

Source files
------------

// File: rtl/parking_fee_calc.sv
// parking_fee_calc: per-slot arrival stamps and a departure fee calculator.
// A departure runs a small FSM: CALC forms the stay length (wrapping at
// midnight), DIV counts started hours by repeated subtraction of 60.
// Optional build macro FEE_CAP_EN: limits each fee to FEE_CAP.
module parking_fee_calc #(
    parameter int N_SLOTS   = 4,
    parameter int RATE      = 5,
    parameter int GRACE_MIN = 15,
    parameter int FEE_CAP   = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         hour,
    input  logic [5:0]         minute,
    input  logic               car_in,
    input  logic               car_out,
    input  logic [1:0]         slot,
    output logic               busy,
    output logic               done,
    output logic [7:0]         fee,
    output logic [10:0]        elapsed,
    output logic [N_SLOTS-1:0] occupied,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV} state_t;

`ifdef FEE_CAP_EN
    localparam int CAP_LIM = (FEE_CAP < 255) ? FEE_CAP : 255;
`else
    // No cap in this build: only the 8-bit output saturation applies,
    // so FEE_CAP contributes nothing to the limit.
    localparam int CAP_LIM = 255 + 0 * FEE_CAP;
`endif

    // Minutes since midnight for the current upstream time.
    function automatic logic [10:0] stamp(input logic [5:0] hr, input logic [5:0] mn);
        return 11'({5'd0, hr} * 11'd60 + {5'd0, mn});
    endfunction

    // Grace rule, hourly rate, then cap / 8-bit saturation.
    function automatic logic [7:0] fee_of(input logic [4:0] hrs, input logic [10:0] span);
        logic [31:0] raw;
        raw = 32'(hrs) * 32'(RATE);
        if (32'(span) < 32'(GRACE_MIN)) return 8'd0;
        if (raw > 32'(CAP_LIM)) raw = 32'(CAP_LIM);
        return raw[7:0];
    endfunction

    function automatic logic slot_ok(input logic [1:0] s);
        return (32'(s) < 32'(N_SLOTS));
    endfunction

    state_t             state_q, state_d;
    logic [N_SLOTS-1:0] occupied_q, occupied_d;
    logic [7:0]         fee_q, fee_d;
    logic [10:0]        elapsed_q, elapsed_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [10:0]        entry_q [N_SLOTS];
    logic [10:0]        entry_d [N_SLOTS];
    logic [10:0]        exit_q, exit_d;
    logic [1:0]         slot_q, slot_d;
    logic [10:0]        rem_q, rem_d;
    logic [4:0]         h_q, h_d;
    logic [10:0]        span_q, span_d;

    logic [10:0]        now;
    logic [10:0]        entry_sel;
    logic [10:0]        span_calc;
    logic [10:0]        step;

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign fee      = fee_q;
    assign elapsed  = elapsed_q;
    assign occupied = occupied_q;

    // Request handling and the CALC/DIV sequence.
    always_comb begin
        state_d    = state_q;
        occupied_d = occupied_q;
        fee_d      = fee_q;
        elapsed_d  = elapsed_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        entry_d    = entry_q;
        exit_d     = exit_q;
        slot_d     = slot_q;
        rem_d      = rem_q;
        h_d        = h_q;
        span_d     = span_q;
        now        = stamp(hour, minute);
        entry_sel  = entry_q[slot_q];
        span_calc  = 11'd0;
        step       = 11'd0;

        case (state_q)
            S_IDLE: begin
                if (car_in && car_out) begin
                    err_d = 1'b1;
                end else if (car_in) begin
                    if (!slot_ok(slot) || occupied_q[slot]) begin
                        err_d = 1'b1;
                    end else begin
                        occupied_d[slot] = 1'b1;
                        entry_d[slot]    = now;
                    end
                end else if (car_out) begin
                    if (!slot_ok(slot) || !occupied_q[slot]) begin
                        err_d = 1'b1;
                    end else begin
                        exit_d  = now;
                        slot_d  = slot;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                // Midnight crossing: add a full day before subtracting.
                if (exit_q >= entry_sel) span_calc = exit_q - entry_sel;
                else                     span_calc = 11'(12'(exit_q) + 12'd1440 - 12'(entry_sel));
                span_d = span_calc;
                rem_d  = span_calc;
                h_d    = 5'd0;
                if (span_calc == 11'd0) begin
                    state_d            = S_IDLE;
                    done_d             = 1'b1;
                    fee_d              = fee_of(5'd0, span_calc);
                    elapsed_d          = span_calc;
                    occupied_d[slot_q] = 1'b0;
                end else begin
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                step  = (rem_q > 11'd60) ? 11'd60 : rem_q;
                rem_d = rem_q - step;
                h_d   = h_q + 5'd1;
                if (rem_d == 11'd0) begin
                    state_d            = S_IDLE;
                    done_d             = 1'b1;
                    fee_d              = fee_of(h_d, span_q);
                    elapsed_d          = span_q;
                    occupied_d[slot_q] = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Control and visible results, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            occupied_q <= '0;
            fee_q      <= 8'd0;
            elapsed_q  <= 11'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occupied_q <= occupied_d;
            fee_q      <= fee_d;
            elapsed_q  <= elapsed_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Working data; only meaningful under the control state above.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
        exit_q  <= exit_d;
        slot_q  <= slot_d;
        rem_q   <= rem_d;
        h_q     <= h_d;
        span_q  <= span_d;
    end

endmodule

// File: tb/tb_parking_fee_calc.sv
// Directed bench for parking_fee_calc with hand-computed expectations.
module tb_parking_fee_calc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  hour = '0;
    logic [5:0]  minute = '0;
    logic        car_in = 1'b0;
    logic        car_out = 1'b0;
    logic [1:0]  slot = '0;
    logic        busy;
    logic        done;
    logic [7:0]  fee;
    logic [10:0] elapsed;
    logic [3:0]  occupied;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef FEE_CAP_EN
    localparam int EXP_LONG_FEE = 50;
`else
    localparam int EXP_LONG_FEE = 120;
`endif

    parking_fee_calc dut (
        .clk(clk), .reset(reset), .hour(hour), .minute(minute),
        .car_in(car_in), .car_out(car_out), .slot(slot),
        .busy(busy), .done(done), .fee(fee), .elapsed(elapsed),
        .occupied(occupied), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic req(input logic ci, input logic co, input logic [1:0] s, input int hr, input int mn);
        car_in  = ci;
        car_out = co;
        slot    = s;
        hour    = 6'(hr);
        minute  = 6'(mn);
        @(posedge clk); #1;
        car_in  = 1'b0;
        car_out = 1'b0;
    endtask

    task automatic arrive(input logic [1:0] s, input int hr, input int mn, input logic [3:0] exp_occ);
        req(1'b1, 1'b0, s, hr, mn);
        chk("arrive_occ", occupied, exp_occ);
        chk("arrive_err", err, 0);
        chk("arrive_busy", busy, 0);
        chk("arrive_done", done, 0);
    endtask

    task automatic depart(input logic [1:0] s, input int hr, input int mn, input int exp_el,
                          input int exp_fee, input int exp_lat, input logic [3:0] exp_occ);
        int cnt;
        req(1'b0, 1'b1, s, hr, mn);
        cnt = 1;
        chk("depart_busy_c1", busy, 1);
        chk("depart_done_c1", done, 0);
        while (!done && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("depart_latency", cnt, exp_lat);
        chk("depart_elapsed", elapsed, exp_el);
        chk("depart_fee", fee, exp_fee);
        chk("depart_busy_done", busy, 0);
        chk("depart_occ", occupied, exp_occ);
        @(posedge clk); #1;
        chk("depart_done_pulse", done, 0);
        chk("depart_fee_hold", fee, exp_fee);
        chk("depart_elapsed_hold", elapsed, exp_el);
    endtask

    initial begin
        int n_done;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_fee", fee, 0);
        chk("rst_elapsed", elapsed, 0);
        chk("rst_occ", occupied, 0);

        // 10:05 -> 12:06 : 121 min, 3 h, fee 15, done 5 cycles after acceptance
        arrive(2'd1, 10, 5, 4'b0010);
        depart(2'd1, 12, 6, 121, 15, 5, 4'b0000);

        // Midnight crossing 23:50 -> 00:20 : 30 min, fee 5
        arrive(2'd0, 23, 50, 4'b0001);
        depart(2'd0, 0, 20, 30, 5, 3, 4'b0000);

        // 10 minute stay inside grace
        arrive(2'd2, 9, 0, 4'b0100);
        depart(2'd2, 9, 10, 10, 0, 3, 4'b0000);

        // Grace boundary: 15 charges, 14 is free
        arrive(2'd1, 3, 0, 4'b0010);
        depart(2'd1, 3, 15, 15, 5, 3, 4'b0000);
        arrive(2'd1, 3, 0, 4'b0010);
        depart(2'd1, 3, 14, 14, 0, 3, 4'b0000);

        // Rejected requests
        arrive(2'd3, 1, 0, 4'b1000);
        req(1'b1, 1'b0, 2'd3, 1, 5);
        chk("err_in_occupied", err, 1);
        chk("err_in_occ_state", occupied, 4'b1000);
        chk("err_in_done", done, 0);
        @(posedge clk); #1;
        chk("err_pulse_drop", err, 0);
        req(1'b0, 1'b1, 2'd0, 1, 5);
        chk("err_out_free", err, 1);
        chk("err_out_busy", busy, 0);
        chk("err_out_occ", occupied, 4'b1000);
        req(1'b1, 1'b1, 2'd3, 1, 5);
        chk("err_both", err, 1);
        chk("err_both_busy", busy, 0);
        chk("err_both_occ", occupied, 4'b1000);
        @(posedge clk); #1;
        chk("err_both_drop", err, 0);
        chk("err_both_done", done, 0);

        // Zero-length stay; an arrival issued while busy is ignored silently
        req(1'b0, 1'b1, 2'd3, 1, 0);
        chk("zero_busy_c1", busy, 1);
        car_in = 1'b1;
        slot   = 2'd1;
        @(posedge clk); #1;
        car_in = 1'b0;
        chk("zero_done_lat2", done, 1);
        chk("zero_elapsed", elapsed, 0);
        chk("zero_fee", fee, 0);
        chk("ignored_err", err, 0);
        chk("ignored_occ", occupied, 4'b0000);
        @(posedge clk); #1;
        chk("ignored_err_late", err, 0);
        chk("ignored_occ_late", occupied, 4'b0000);

        // 08:00 -> 07:59 : 1439 min, 24 h
        arrive(2'd0, 8, 0, 4'b0001);
        depart(2'd0, 7, 59, 1439, EXP_LONG_FEE, 26, 4'b0000);

        // Reset during DIV aborts the calculation
        arrive(2'd1, 10, 0, 4'b0010);
        arrive(2'd2, 10, 0, 4'b0110);
        req(1'b0, 1'b1, 2'd2, 13, 0);
        @(posedge clk); #1;
        chk("abort_busy_div", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_occ", occupied, 0);
        chk("abort_done", done, 0);
        chk("abort_fee", fee, 0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        arrive(2'd0, 5, 0, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
